// File: rtl/fetch_unit_if.sv
// Decode-side handshake bundle for the fetch stage.
// master drives valid/instr/pc/pc_plus1, slave returns ready.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 32
);
  logic                  dec_valid;
  logic                  dec_ready;
  logic [WORD_SIZE-1:0]  dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic [ADDR_WIDTH-1:0] dec_pc_plus1;

  modport master (
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_pc_plus1
  );

  modport slave (
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_pc_plus1
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 2-entry fetch queue, redirect, halt.
// Ports: clk, rst (async low), instr_* mem port, redirect_*, dec (if), halted.
module fetch_unit #(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  WORD_SIZE  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [WORD_SIZE-1:0]  HALT_WORD = '1,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] instr_read_address,
  input  logic [WORD_SIZE-1:0]  instr_instruction,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  halted,
  fetch_unit_if.master          dec
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] LP_FULL = 2'(FIFO_DEPTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [1:0]            r_count;
  logic                  r_halted;
  logic [WORD_SIZE-1:0]  r_q_instr [0:1];
  logic [ADDR_WIDTH-1:0] r_q_pc    [0:1];

  logic w_valid;
  logic w_pop;
  logic w_fire;
  logic w_is_halt;

  assign w_valid   = (r_count != 2'd0);
  assign w_pop     = w_valid & dec.dec_ready;
  // A full queue can still accept a push when its head leaves this cycle.
  assign w_fire    = (r_state == S_RUN) & ~redirect_valid
                   & ((r_count != LP_FULL) | w_pop);
  assign w_is_halt = (instr_instruction == HALT_WORD);

  assign instr_read_address = r_pc;
  assign halted             = r_halted;
  assign dec.dec_valid      = w_valid;
  assign dec.dec_instr      = r_q_instr[0];
  assign dec.dec_pc         = r_q_pc[0];
  assign dec.dec_pc_plus1   = r_q_pc[0] + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_count      <= 2'd0;
      r_halted     <= 1'b0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over everything; a coincident pop still completes.
      r_state  <= S_RUN;
      r_pc     <= redirect_target;
      r_count  <= 2'd0;
      r_halted <= 1'b0;
    end else begin
      if (r_state == S_BOOT)
        r_state <= S_RUN;

      if (w_fire) begin
        r_pc <= r_pc + 1'b1;
        if (w_is_halt) begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
      end

      unique case (1'b1)
        (w_pop & w_fire): begin
          if (r_count == LP_FULL) begin
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[0]    <= r_q_pc[1];
            r_q_instr[1] <= instr_instruction;
            r_q_pc[1]    <= r_pc;
          end else begin
            r_q_instr[0] <= instr_instruction;
            r_q_pc[0]    <= r_pc;
          end
        end
        (w_pop & ~w_fire): begin
          r_q_instr[0] <= r_q_instr[1];
          r_q_pc[0]    <= r_q_pc[1];
          r_count      <= r_count - 2'd1;
        end
        (~w_pop & w_fire): begin
          if (r_count == 2'd0) begin
            r_q_instr[0] <= instr_instruction;
            r_q_pc[0]    <= r_pc;
          end else begin
            r_q_instr[1] <= instr_instruction;
            r_q_pc[1]    <= r_pc;
          end
          r_count <= r_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
// Directed phases cover boot, backpressure, redirect, halt, wrap, async reset.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [7:0]  instr_read_address;
  logic [31:0] instr_instruction;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halted;

  logic [31:0] mem [256];

  fetch_unit_if u_if ();

  fetch_unit u_dut (
    .clk                (clk),
    .rst                (rst),
    .instr_read_address (instr_read_address),
    .instr_instruction  (instr_instruction),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .halted             (halted),
    .dec                (u_if)
  );

  assign instr_instruction = mem[instr_read_address];

  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [7:0]  m_pc;
  bit          m_boot;
  bit          m_halt;
  logic [31:0] m_qi [$];
  logic [7:0]  m_qp [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 8'h00;
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_qi.delete();
    m_qp.delete();
  endtask

  // One clock of the reference: what the stage should hold after the edge.
  task automatic model_step(input bit rv, input logic [7:0] tgt,
                            input bit rdy);
    bit pop;
    pop = rdy && (m_qi.size() > 0);
    if (rv) begin
      m_qi.delete();
      m_qp.delete();
      m_pc   = tgt;
      m_boot = 1'b0;
      m_halt = 1'b0;
      return;
    end
    if (pop) begin
      void'(m_qi.pop_front());
      void'(m_qp.pop_front());
    end
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (!m_halt && m_qi.size() < 2) begin
      m_qi.push_back(mem[m_pc]);
      m_qp.push_back(m_pc);
      if (mem[m_pc] == HALT) m_halt = 1'b1;
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic check_outs();
    logic [7:0] nxt;
    chk("addr", instr_read_address, m_pc);
    chk("valid", u_if.dec_valid, m_qi.size() > 0);
    chk("halted", halted, m_halt);
    if (m_qi.size() > 0) begin
      nxt = m_qp[0] + 8'd1;
      chk("instr", u_if.dec_instr, m_qi[0]);
      chk("pc", u_if.dec_pc, m_qp[0]);
      chk("pc1", u_if.dec_pc_plus1, nxt);
    end
  endtask

  // Called at a negedge: check, drive, advance model, wait one cycle.
  task automatic cyc(input bit rv, input logic [7:0] tgt, input bit rdy);
    check_outs();
    redirect_valid    = rv;
    redirect_target   = tgt;
    u_if.dec_ready    = rdy;
    model_step(rv, tgt, rdy);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'h00;
    u_if.dec_ready  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'h0;
    end
    mem[5] = HALT;
    model_reset();

    #1;
    chk("rst_addr", instr_read_address, 8'h00);
    chk("rst_valid", u_if.dec_valid, 1'b0);
    chk("rst_instr", u_if.dec_instr, 32'h0);
    chk("rst_pc", u_if.dec_pc, 8'h00);
    chk("rst_halted", halted, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch with decode always ready.
    run(5, 1'b1);

    // Backpressure: fill, hold, then drain.
    cyc(1'b1, 8'h00, 1'b0);
    run(5, 1'b0);
    chk("bp_addr", instr_read_address, 8'h02);
    run(4, 1'b1);

    // Redirect while the queue is full.
    cyc(1'b1, 8'h00, 1'b0);
    run(3, 1'b0);
    cyc(1'b1, 8'h80, 1'b0);
    run(3, 1'b1);

    // Halt word at address 5 parks the PC at 6.
    cyc(1'b1, 8'h00, 1'b1);
    run(10, 1'b1);
    chk("park_addr", instr_read_address, 8'h06);
    chk("park_halted", halted, 1'b1);
    cyc(1'b1, 8'h10, 1'b1);
    run(4, 1'b1);

    // Address wrap.
    cyc(1'b1, 8'hFE, 1'b1);
    run(5, 1'b1);

    // Random traffic with sprinkled halt words.
    for (int i = 0; i < 256; i++)
      if ($urandom_range(0, 15) == 0) mem[i] = HALT;
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) == 0, 8'($urandom),
          $urandom_range(0, 9) < 7);

    // Fill the queue, then reset between edges.
    cyc(1'b1, 8'h40, 1'b0);
    run(4, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_addr", instr_read_address, 8'h00);
    chk("arst_valid", u_if.dec_valid, 1'b0);
    chk("arst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of cpumemory's instruction read port.
- Holds the PC and drives instr_read_address. Samples instr_instruction in the same cycle.
- Buffers fetched words in a 2-entry queue and hands {instruction, pc} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and a halt word.

Parameters:
- ADDR_WIDTH, 8, word-address width; matches cpumemory's 256-word array.
- WORD_SIZE, 32, instruction width.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch.
- FIFO_DEPTH, 2, fetch-queue entries; fixed at 2 for this revision.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- instr_read_address  output  ADDR_WIDTH  word address to cpumemory; equals the PC register.
- instr_instruction  input  WORD_SIZE  combinational read data from cpumemory for instr_read_address.
- redirect_valid  input  1  load a new PC this cycle (branch/jump taken).
- redirect_target  input  ADDR_WIDTH  new PC when redirect_valid=1.
- dec_valid  output  1  queue head valid.
- dec_ready  input  1  decode accepts head this cycle.
- dec_instr  output  WORD_SIZE  queue head instruction.
- dec_pc  output  ADDR_WIDTH  word address the head was fetched from.
- dec_pc_plus1  output  ADDR_WIDTH  dec_pc+1, modulo 2^ADDR_WIDTH.
- halted  output  1  fetch stopped on HALT_WORD.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed): pc=RESET_PC, so instr_read_address=RESET_PC. Queue count=0; dec_valid=0; dec_instr=0; dec_pc=0; halted=0; state=BOOT.
- FSM states:
  - BOOT: exactly one cycle after reset release, no fetch; transitions to RUN.
  - RUN: fetching.
  - HALTED: no fetch; halted=1.
- pop: dec_valid & dec_ready at a posedge. Decode owns the popped entry.
- fire (RUN only): redirect_valid=0 & (count<2 | pop). On fire, push {instr_instruction, pc} and set pc<=pc+1, wrapping 255->0.
- Fetch latency: the word addressed in cycle N appears on dec_instr in cycle N+1 at the earliest. Queue outputs come from registers, not from instr_instruction.
- Throughput: 1 instruction per cycle when dec_ready is held high.
- Halt: if a fired word equals HALT_WORD:
  - the word is still pushed;
  - pc increments;
  - state -> HALTED; halted=1 from the next cycle.
- HALTED is left only via redirect; the queue keeps draining normally while halted.
- Redirect (any state incl. BOOT, highest priority):
  - pc<=redirect_target; queue flushed (count=0); no push that cycle; state->RUN; halted->0.
  - A pop coinciding with the redirect completes the handshake; the flush discards the remaining entries.
- Queue rules:
  - count is in 0..2.
  - Push+pop while full is legal; count stays 2.
  - Push+pop while count=1: head becomes the new entry.
  - Pop on empty is impossible, since dec_valid=0.
- Hold rule: while dec_valid & !dec_ready, dec_instr/dec_pc stay stable and the PC stalls once the queue is full.
- dec_instr/dec_pc when dec_valid=0: hold last value; no contract.
- No tracking of data-port writes to instruction addresses: fetch returns whatever cpumemory presents that cycle (self-modifying code is the software's responsibility).

Test Plan:
- Sequential fetch: mem[0..3]=A,B,C,D, dec_ready=1, release rst → BOOT cycle, then instr_read_address 0,1,2,3 on consecutive cycles. dec_valid rises 2 cycles after release with A/pc0, then B/pc1, C/pc2 back-to-back; dec_pc_plus1=dec_pc+1.
- Backpressure: dec_ready=0 from start → address stops at 2 with count=2 and dec_instr=A held. Raise dec_ready for 4 cycles → A,B,C,D delivered in order, no loss or duplication.
- Redirect with full queue: queue holds pc0/pc1, redirect_valid=1 target 8'h80 → next cycle dec_valid=0 and address 0x80. One cycle later dec_instr=mem[0x80], dec_pc=0x80.
- Halt: mem[5]=32'hFFFFFFFF → word delivered with dec_pc=5, halted=1, address parked at 6, nothing further pushed. Redirect to 0x10 → halted=0, fetch resumes at 0x10.
- Wrap: redirect to 8'hFE → dec_pc sequence FE, FF, 00; dec_pc_plus1=00 when dec_pc=FF.
- Async reset mid-stream: drop rst between clock edges with count=2 → dec_valid=0, halted=0 and instr_read_address=RESET_PC before the next posedge. After release, BOOT then fetch from RESET_PC.
